// File: rtl/result_uart_tx.sv
// result_uart_tx
// Samples the physics core's 8-bit RESULT bus on each SampleTick strobe and
// queues the captured bytes in a 4-entry FIFO. With CHANGE_ONLY set, only
// values that differ from the last queued one are captured. Queued bytes are
// sent as 8N1 UART frames (start bit, 8 data bits LSB first, stop bit) on TxD.
//
// Parameters:
//   BAUD_DIV    - clock cycles per UART bit, legal range 2..4095
//   CHANGE_ONLY - 1: capture only changed values, 0: capture every tick
// Ports:
//   FPGAClock  in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   RESULT     in   [7:0] raw core result
//   SampleTick in   one-cycle sample strobe
//   Enable     in   capture enable; queued frames still drain when low
//   TxD        out  UART line, idle high, registered
//   Busy       out  transmitter not idle
//   FifoCount  out  [2:0] occupied FIFO entries, 0..4
//   Overflow   out  sticky dropped-push flag, cleared only by Reset
module result_uart_tx #(
    parameter int BAUD_DIV    = 87,
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic       FPGAClock,
    input  logic       Reset,
    input  logic [7:0] RESULT,
    input  logic       SampleTick,
    input  logic       Enable,
    output logic       TxD,
    output logic       Busy,
    output logic [2:0] FifoCount,
    output logic       Overflow
);

    localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t   state_reg, state_next;
    logic [11:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_reg, txd_next;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [2:0]  count_reg, count_next;
    logic        overflow_reg;
    logic        first_reg;
    logic [7:0]  last_reg;

    logic        pop;
    logic        capture;
    logic        push;
    logic        drop;
    logic [7:0]  head;

    // The head is read combinationally: a pop must load the shift register in
    // the same cycle so back-to-back frames have no gap after the stop bit.
    assign head = fifo_mem[rd_ptr_reg];

    // ------------------------------------------------------------------
    // Capture / push decision
    // ------------------------------------------------------------------
    always_comb begin
        capture = SampleTick & Enable &
                  (~CHANGE_ONLY | first_reg | (RESULT != last_reg));
        // A full FIFO still accepts when the transmitter pops this cycle.
        push    = capture & ((count_reg != 3'd4) | pop);
        drop    = capture & ~push;
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM, next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg - 12'd1;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        txd_next      = txd_reg;
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next      = 1'b1;
                baud_cnt_next = BAUD_RELOAD;
                if (count_reg != 3'd0) begin
                    pop        = 1'b1;
                    shift_next = head;
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (baud_cnt_reg == 12'd0) begin
                    state_next    = DATA;
                    baud_cnt_next = BAUD_RELOAD;
                    bit_idx_next  = 3'd0;
                    txd_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_cnt_reg == 12'd0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        // Shift so the bit on the line is always shift_reg[0].
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        txd_next     = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (baud_cnt_reg == 12'd0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    if (count_reg != 3'd0) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge FPGAClock) begin
        if (Reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= BAUD_RELOAD;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
        end
    end

    always_ff @(posedge FPGAClock) begin
        if (Reset) begin
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            overflow_reg <= 1'b0;
            first_reg    <= 1'b1;
            last_reg     <= 8'd0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
                first_reg  <= 1'b0;
                last_reg   <= RESULT;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge FPGAClock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= RESULT;
        end
    end

    assign TxD       = txd_reg;
    assign Busy      = (state_reg != IDLE);
    assign FifoCount = count_reg;
    assign Overflow  = overflow_reg;

endmodule

// File: tb/tb_result_uart_tx.sv
// Testbench for result_uart_tx. Three instances share the stimulus:
//   a: BAUD_DIV=4, CHANGE_ONLY=1
//   b: BAUD_DIV=4, CHANGE_ONLY=0
//   c: BAUD_DIV=8, CHANGE_ONLY=1
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_result_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] result = 8'd0;
    logic       tick = 1'b0;
    logic       en = 1'b1;

    logic       txd_a, busy_a, ovf_a;
    logic [2:0] cnt_a;
    logic       txd_b, busy_b, ovf_b;
    logic [2:0] cnt_b;
    logic       txd_c, busy_c, ovf_c;
    logic [2:0] cnt_c;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    result_uart_tx #(.BAUD_DIV(4), .CHANGE_ONLY(1'b1)) dut_a (
        .FPGAClock(clk), .Reset(rst), .RESULT(result), .SampleTick(tick),
        .Enable(en), .TxD(txd_a), .Busy(busy_a), .FifoCount(cnt_a), .Overflow(ovf_a)
    );
    result_uart_tx #(.BAUD_DIV(4), .CHANGE_ONLY(1'b0)) dut_b (
        .FPGAClock(clk), .Reset(rst), .RESULT(result), .SampleTick(tick),
        .Enable(en), .TxD(txd_b), .Busy(busy_b), .FifoCount(cnt_b), .Overflow(ovf_b)
    );
    result_uart_tx #(.BAUD_DIV(8), .CHANGE_ONLY(1'b1)) dut_c (
        .FPGAClock(clk), .Reset(rst), .RESULT(result), .SampleTick(tick),
        .Enable(en), .TxD(txd_c), .Busy(busy_c), .FifoCount(cnt_c), .Overflow(ovf_c)
    );

    // Expected line level k cycles after the first start bit began, for
    // n back-to-back frames; byte f sits in bytes[8f+7:8f].
    function automatic logic exp_txd(input int k, input int baud,
                                     input logic [63:0] bytes, input int n);
        int f;
        int pos;
        if (k < 0) return 1'b1;
        f   = k / (10 * baud);
        pos = (k % (10 * baud)) / baud;
        if (f >= n) return 1'b1;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return bytes[8 * f + pos - 1];
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (txd_a !== 1'b1) $display("FAIL reset_txd got %b want 1", txd_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (cnt_a !== 3'd0) $display("FAIL reset_count got %0d want 0", cnt_a); else pass_cnt++;
        total_cnt++; if (ovf_a !== 1'b0) $display("FAIL reset_overflow got %b want 0", ovf_a); else pass_cnt++;
        total_cnt++; if (txd_c !== 1'b1 || cnt_c !== 3'd0) $display("FAIL reset_c got txd=%b cnt=%0d want 1/0", txd_c, cnt_c); else pass_cnt++;
        $display("test_reset done");
    endtask

    // Negedge c drives the inputs for edge N+c; outputs seen at negedge c
    // reflect edge N+c-1, so k = c-2 counts cycles from the first start bit.
    task automatic test_single_byte();
        do_reset();
        for (int c = 0; c <= 43; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total_cnt++; if (cnt_a !== 3'd1) $display("FAIL single_count got %0d want 1", cnt_a); else pass_cnt++;
                total_cnt++; if (txd_a !== 1'b1) $display("FAIL single_txd_pre got %b want 1", txd_a); else pass_cnt++;
            end
            if (c >= 2) begin
                total_cnt++;
                if (txd_a !== exp_txd(c - 2, 4, 64'hA5, 1))
                    $display("FAIL single_txd k=%0d got %b want %b", c - 2, txd_a, exp_txd(c - 2, 4, 64'hA5, 1));
                else pass_cnt++;
            end
            if (c == 41) begin
                total_cnt++; if (busy_a !== 1'b1) $display("FAIL single_busy_stop got %b want 1", busy_a); else pass_cnt++;
            end
            if (c == 42) begin
                total_cnt++; if (busy_a !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy_a); else pass_cnt++;
            end
            tick   = (c == 0);
            result = 8'hA5;
        end
        tick = 1'b0;
        $display("test_single_byte done: 0xA5 sent");
    endtask

    task automatic test_change_only();
        do_reset();
        for (int c = 0; c <= 164; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 84) begin
                total_cnt++;
                if (txd_a !== exp_txd(c - 2, 4, 64'h2210, 2))
                    $display("FAIL change1_txd k=%0d got %b want %b", c - 2, txd_a, exp_txd(c - 2, 4, 64'h2210, 2));
                else pass_cnt++;
            end
            if (c >= 2) begin
                total_cnt++;
                if (txd_b !== exp_txd(c - 2, 4, 64'h22101010, 4))
                    $display("FAIL change0_txd k=%0d got %b want %b", c - 2, txd_b, exp_txd(c - 2, 4, 64'h22101010, 4));
                else pass_cnt++;
            end
            if (c == 81) begin
                total_cnt++; if (busy_a !== 1'b1) $display("FAIL change1_busy_last got %b want 1", busy_a); else pass_cnt++;
            end
            if (c == 82) begin
                total_cnt++; if (busy_a !== 1'b0) $display("FAIL change1_busy_end got %b want 0", busy_a); else pass_cnt++;
            end
            if (c == 162) begin
                total_cnt++; if (busy_b !== 1'b0) $display("FAIL change0_busy_end got %b want 0", busy_b); else pass_cnt++;
            end
            tick   = (c == 0 || c == 2 || c == 4 || c == 6);
            result = (c == 6) ? 8'h22 : 8'h10;
        end
        tick = 1'b0;
        $display("test_change_only done: 2 frames (change-only) and 4 frames (every tick)");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c <= 405; c++) begin
            @(negedge clk);
            if (c == 5) begin
                total_cnt++; if (cnt_c !== 3'd4) $display("FAIL ovf_full_count got %0d want 4", cnt_c); else pass_cnt++;
                total_cnt++; if (ovf_c !== 1'b0) $display("FAIL ovf_before got %b want 0", ovf_c); else pass_cnt++;
            end
            if (c == 6) begin
                total_cnt++; if (ovf_c !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf_c); else pass_cnt++;
                total_cnt++; if (cnt_c !== 3'd4) $display("FAIL ovf_count_after_drop got %0d want 4", cnt_c); else pass_cnt++;
            end
            if (c >= 2) begin
                total_cnt++;
                if (txd_c !== exp_txd(c - 2, 8, 64'h0504030201, 5))
                    $display("FAIL ovf_txd k=%0d got %b want %b", c - 2, txd_c, exp_txd(c - 2, 8, 64'h0504030201, 5));
                else pass_cnt++;
            end
            tick   = (c <= 5);
            result = 8'(c + 1);
        end
        tick = 1'b0;
        total_cnt++; if (ovf_c !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf_c); else pass_cnt++;
        total_cnt++; if (busy_c !== 1'b0 || cnt_c !== 3'd0) $display("FAIL ovf_drained got busy=%b cnt=%0d want 0/0", busy_c, cnt_c); else pass_cnt++;
        do_reset();
        total_cnt++; if (ovf_c !== 1'b0) $display("FAIL ovf_cleared got %b want 0", ovf_c); else pass_cnt++;
        $display("test_overflow done: 1..5 sent, 6 dropped");
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c <= 244; c++) begin
            @(negedge clk);
            if (c == 41) begin
                total_cnt++; if (cnt_a !== 3'd4) $display("FAIL fullpp_count_before got %0d want 4", cnt_a); else pass_cnt++;
            end
            if (c == 42) begin
                total_cnt++; if (cnt_a !== 3'd4) $display("FAIL fullpp_count_after got %0d want 4", cnt_a); else pass_cnt++;
                total_cnt++; if (ovf_a !== 1'b0) $display("FAIL fullpp_overflow got %b want 0", ovf_a); else pass_cnt++;
            end
            if (c >= 2) begin
                total_cnt++;
                if (txd_a !== exp_txd(c - 2, 4, 64'h060504030201, 6))
                    $display("FAIL fullpp_txd k=%0d got %b want %b", c - 2, txd_a, exp_txd(c - 2, 4, 64'h060504030201, 6));
                else pass_cnt++;
            end
            tick   = (c <= 4) || (c == 41);
            result = (c == 41) ? 8'h06 : 8'(c + 1);
        end
        tick = 1'b0;
        total_cnt++; if (ovf_a !== 1'b0) $display("FAIL fullpp_overflow_end got %b want 0", ovf_a); else pass_cnt++;
        $display("test_full_push_pop done: 1..6 sent");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            if (c == 18) begin
                total_cnt++; if (txd_a !== 1'b0) $display("FAIL midrst_bit3 got %b want 0", txd_a); else pass_cnt++;
                total_cnt++; if (cnt_a !== 3'd1) $display("FAIL midrst_queued got %0d want 1", cnt_a); else pass_cnt++;
            end
            if (c == 19) begin
                total_cnt++; if (txd_a !== 1'b1) $display("FAIL midrst_txd got %b want 1", txd_a); else pass_cnt++;
                total_cnt++; if (cnt_a !== 3'd0) $display("FAIL midrst_count got %0d want 0", cnt_a); else pass_cnt++;
                total_cnt++; if (busy_a !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_a); else pass_cnt++;
            end
            if (c == 21) begin
                total_cnt++; if (cnt_a !== 3'd1) $display("FAIL midrst_first_capture got %0d want 1", cnt_a); else pass_cnt++;
            end
            if (c == 22) begin
                total_cnt++; if (txd_a !== 1'b0 || busy_a !== 1'b1) $display("FAIL midrst_restart got txd=%b busy=%b want 0/1", txd_a, busy_a); else pass_cnt++;
            end
            rst    = (c == 18);
            tick   = (c == 0 || c == 1 || c == 20);
            result = (c == 0) ? 8'hA5 : 8'h33;
        end
        tick = 1'b0;
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk);
            if (c == 2) begin
                total_cnt++; if (cnt_a !== 3'd0 || txd_a !== 1'b1) $display("FAIL enable_off got cnt=%0d txd=%b want 0/1", cnt_a, txd_a); else pass_cnt++;
            end
            if (c == 4) begin
                total_cnt++; if (cnt_a !== 3'd1) $display("FAIL enable_on_count got %0d want 1", cnt_a); else pass_cnt++;
            end
            if (c == 11) begin
                total_cnt++; if (cnt_a !== 3'd0 || busy_a !== 1'b1) $display("FAIL enable_drop got cnt=%0d busy=%b want 0/1", cnt_a, busy_a); else pass_cnt++;
            end
            if (c == 44) begin
                total_cnt++; if (busy_a !== 1'b1) $display("FAIL enable_drain_busy got %b want 1", busy_a); else pass_cnt++;
            end
            if (c == 45) begin
                total_cnt++; if (busy_a !== 1'b0) $display("FAIL enable_drain_end got %b want 0", busy_a); else pass_cnt++;
            end
            en     = (c == 3);
            tick   = (c == 0 || c == 3 || c == 10);
            result = (c == 10) ? 8'h44 : 8'h77;
        end
        tick = 1'b0;
        en   = 1'b1;
        $display("test_enable done");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_change_only();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_enable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
